// File: rtl/transfer_link_pkg.sv
// Shared constants and types for the transfer link scheduler.
package transfer_link_pkg;

   localparam logic [7:0] IDLE_BYTE  = 8'h00;

   // Command codes understood by the transfer center
   localparam logic [7:0] CMD_RESET  = 8'd1;
   localparam logic [7:0] CMD_CONFIG = 8'd2;
   localparam logic [7:0] CMD_STATUS = 8'd3;
   localparam logic [7:0] CMD_START  = 8'd4;
   localparam logic [7:0] CMD_STOP   = 8'd5;
   localparam logic [7:0] CMD_READ   = 8'd6;
   localparam logic [7:0] CMD_BINARY = 8'd7;
   localparam logic [7:0] CMD_SYNC   = 8'd8;

   // The one command that carries a trailing data byte
   localparam logic [7:0] BINARY_CMD = CMD_BINARY;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. The pointer names the requester
// that has priority; after a grant it moves to the other requester.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr_q;

   // Priority-ordered one-hot grant
   always_comb begin
      grant = 2'b00;
      if (ptr_q == 1'b0) begin
         if (req[0])      grant = 2'b01;
         else if (req[1]) grant = 2'b10;
      end else begin
         if (req[1])      grant = 2'b10;
         else if (req[0]) grant = 2'b01;
      end
   end

   // Hand priority to the requester that just lost (or did not ask)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= 1'b0;
      end else if (advance && (grant != 2'b00)) begin
         ptr_q <= grant[0];
      end
   end

endmodule

// File: rtl/transfer_link_scheduler.sv
// Byte-slot scheduler feeding a serial transfer center.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | no frame scheduled, IDLE_BYTE on the line
//   CMD     | captured command byte on the line
//   DATA    | captured data byte following a BINARY_CMD
//
// Decisions are taken in the slot==7 cycle and take effect on the edge
// that wraps slot back to 0. grant is decoded combinationally within that
// cycle so that only req sampled at slot==7 matters.
module transfer_link_scheduler #(
   parameter logic [7:0] IDLE_BYTE  = transfer_link_pkg::IDLE_BYTE,
   parameter logic [7:0] BINARY_CMD = transfer_link_pkg::BINARY_CMD
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [7:0] cmd0,
   input  logic [7:0] cmd1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   input  logic       ready_in,
   output logic [1:0] grant,
   output logic       ser_out,
   output logic [2:0] slot,
   output logic       busy,
   output logic [7:0] frames_sent
);

   import transfer_link_pkg::*;

   state_t     state;
   logic [2:0] slot_q;
   logic [7:0] cmd_q;
   logic [7:0] data_q;
   logic [7:0] frames_q;
   logic [7:0] cur_byte;
   logic [1:0] arb_grant;
   logic       slot_end;
   logic       bin_pending;
   logic       grant_ok;
   logic       granted;

   assign slot_end    = (slot_q == 3'd7);
   // A binary command must be followed by its data byte, so no grant then
   assign bin_pending = (state == ST_CMD) && (cmd_q == BINARY_CMD);
   assign grant_ok    = slot_end && ready_in && !bin_pending;
   assign grant       = grant_ok ? arb_grant : 2'b00;
   assign granted     = (grant != 2'b00);

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (grant_ok),
      .grant   (arb_grant)
   );

   // Free-running bit position within the byte slot
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_q <= 3'd0;
      end else begin
         slot_q <= slot_q + 3'd1;
      end
   end

   // Frame sequencing, capture of the winner and frame completion count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cmd_q    <= 8'h00;
         data_q   <= 8'h00;
         frames_q <= 8'h00;
      end else if (slot_end) begin
         if (granted) begin
            cmd_q  <= grant[1] ? cmd1  : cmd0;
            data_q <= grant[1] ? data1 : data0;
         end
         if (((state == ST_CMD) && !bin_pending) || (state == ST_DATA)) begin
            frames_q <= frames_q + 8'd1;
         end
         case (state)
            ST_IDLE: state <= granted ? ST_CMD : ST_IDLE;
            ST_CMD: begin
               if (bin_pending)  state <= ST_DATA;
               else if (granted) state <= ST_CMD;
               else              state <= ST_IDLE;
            end
            ST_DATA: state <= granted ? ST_CMD : ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Byte currently on the line
   always_comb begin
      cur_byte = IDLE_BYTE;
      case (state)
         ST_CMD:  cur_byte = cmd_q;
         ST_DATA: cur_byte = data_q;
         default: cur_byte = IDLE_BYTE;
      endcase
   end

   assign ser_out     = cur_byte[3'd7 - slot_q];
   assign slot        = slot_q;
   assign busy        = (state != ST_IDLE);
   assign frames_sent = frames_q;

endmodule

// File: tb/tb_transfer_link_scheduler.sv
// Directed bench for transfer_link_scheduler.
module tb_transfer_link_scheduler;

   logic       clk;
   logic       rst;
   logic [1:0] req;
   logic [7:0] cmd0, cmd1, data0, data1;
   logic       ready_in;
   logic [1:0] grant;
   logic       ser_out;
   logic [2:0] slot;
   logic       busy;
   logic [7:0] frames_sent;

   int n_checks = 0;
   int n_errors = 0;

   transfer_link_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .cmd0        (cmd0),
      .cmd1        (cmd1),
      .data0       (data0),
      .data1       (data1),
      .ready_in    (ready_in),
      .grant       (grant),
      .ser_out     (ser_out),
      .slot        (slot),
      .busy        (busy),
      .frames_sent (frames_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_slot7();
      int n;
      n = 0;
      while (slot !== 3'd7 && n < 16) begin
         tick();
         n++;
      end
      chk("slot7_reached", {29'd0, slot}, 32'd7);
   endtask

   // Called at slot 0; samples slots 0..7 and returns at slot 7
   task automatic collect(output logic [7:0] b, output logic all_busy, output logic any_busy);
      b        = 8'h00;
      all_busy = 1'b1;
      any_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) tick();
         b        = {b[6:0], ser_out};
         all_busy = all_busy & busy;
         any_busy = any_busy | busy;
      end
   endtask

   logic [7:0] b;
   logic       ab, yb;
   logic [15:0] idle_bits;
   int         slot_bad;

   initial begin
      rst = 1'b0; req = 2'b00; ready_in = 1'b1;
      cmd0 = 8'h00; cmd1 = 8'h00; data0 = 8'h00; data1 = 8'h00;
      #2;
      chk("rst_slot",   {29'd0, slot}, 32'd0);
      chk("rst_ser",    {31'd0, ser_out}, 32'd0);
      chk("rst_grant",  {30'd0, grant}, 32'd0);
      chk("rst_busy",   {31'd0, busy}, 32'd0);
      chk("rst_frames", {24'd0, frames_sent}, 32'd0);
      #10 rst = 1'b1;

      // Idle line for 16 clocks
      idle_bits = 16'h0; slot_bad = 0; yb = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         idle_bits = {idle_bits[14:0], ser_out};
         yb = yb | busy;
         if (slot !== 3'(i % 8)) slot_bad++;
      end
      chk("idle_ser",  {16'd0, idle_bits}, 32'd0);
      chk("idle_busy", {31'd0, yb}, 32'd0);
      chk("idle_slot_seq", slot_bad, 0);

      // Single non-binary frame from requester 0
      req = 2'b01; cmd0 = 8'd3;
      wait_slot7();
      chk("f1_grant", {30'd0, grant}, 32'h1);
      tick();
      req = 2'b00; cmd0 = 8'hFF;
      collect(b, ab, yb);
      chk("f1_byte", {24'd0, b}, 32'h03);
      chk("f1_busy", {31'd0, ab}, 32'd1);
      chk("f1_end_grant", {30'd0, grant}, 32'h0);
      tick();
      chk("f1_frames", {24'd0, frames_sent}, 32'd1);
      chk("f1_idle_busy", {31'd0, busy}, 32'd0);

      // Binary frame from requester 1
      req = 2'b10; cmd1 = 8'd7; data1 = 8'hA5;
      wait_slot7();
      chk("f2_grant", {30'd0, grant}, 32'h2);
      tick();
      req = 2'b00;
      collect(b, ab, yb);
      chk("f2_cmd", {24'd0, b}, 32'h07);
      chk("f2_cmd_busy", {31'd0, ab}, 32'd1);
      chk("f2_no_grant_cmd", {30'd0, grant}, 32'h0);
      chk("f2_frames_mid", {24'd0, frames_sent}, 32'd1);
      tick();
      collect(b, ab, yb);
      chk("f2_data", {24'd0, b}, 32'hA5);
      chk("f2_data_busy", {31'd0, ab}, 32'd1);
      tick();
      chk("f2_frames", {24'd0, frames_sent}, 32'd2);
      chk("f2_idle_busy", {31'd0, busy}, 32'd0);

      // Both requesting: alternating back-to-back frames
      req = 2'b11; cmd0 = 8'd1; cmd1 = 8'd3;
      wait_slot7();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr_grant%0d", i), {30'd0, grant}, (i % 2 == 0) ? 32'h1 : 32'h2);
         tick();
         if (i == 3) req = 2'b00;
         collect(b, ab, yb);
         chk($sformatf("rr_byte%0d", i), {24'd0, b}, (i % 2 == 0) ? 32'h01 : 32'h03);
         chk($sformatf("rr_busy%0d", i), {31'd0, ab}, 32'd1);
      end
      chk("rr_end_grant", {30'd0, grant}, 32'h0);
      tick();
      chk("rr_frames", {24'd0, frames_sent}, 32'd6);

      // ready_in low blocks grants
      ready_in = 1'b0; req = 2'b01; cmd0 = 8'd5;
      wait_slot7();
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("nr_grant%0d", j), {30'd0, grant}, 32'h0);
         tick();
         collect(b, ab, yb);
         chk($sformatf("nr_byte%0d", j), {24'd0, b}, 32'h00);
         chk($sformatf("nr_busy%0d", j), {31'd0, yb}, 32'd0);
      end
      chk("nr_grant3", {30'd0, grant}, 32'h0);
      tick();
      ready_in = 1'b1;
      wait_slot7();
      chk("nr_grant_after", {30'd0, grant}, 32'h1);
      tick();
      req = 2'b00;
      collect(b, ab, yb);
      chk("nr_byte", {24'd0, b}, 32'h05);
      tick();
      chk("nr_frames", {24'd0, frames_sent}, 32'd7);

      // Reset in the middle of a DATA slot
      req = 2'b01; cmd0 = 8'd7; data0 = 8'h3C;
      wait_slot7();
      chk("rs_grant", {30'd0, grant}, 32'h1);
      tick();
      req = 2'b00;
      collect(b, ab, yb);
      chk("rs_cmd", {24'd0, b}, 32'h07);
      for (int k = 0; k < 5; k++) tick();
      chk("rs_pre_slot", {29'd0, slot}, 32'd4);
      chk("rs_pre_busy", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rs_slot",   {29'd0, slot}, 32'd0);
      chk("rs_ser",    {31'd0, ser_out}, 32'd0);
      chk("rs_busy",   {31'd0, busy}, 32'd0);
      chk("rs_grant0", {30'd0, grant}, 32'h0);
      chk("rs_frames", {24'd0, frames_sent}, 32'd0);
      #3 rst = 1'b1;
      tick();
      chk("rs_post_slot", {29'd0, slot}, 32'd1);
      chk("rs_post_busy", {31'd0, busy}, 32'd0);
      chk("rs_post_ser",  {31'd0, ser_out}, 32'd0);

      // Pointer back at requester 0 after reset
      req = 2'b11; cmd0 = 8'd2; cmd1 = 8'd4;
      wait_slot7();
      chk("rs_ptr_grant", {30'd0, grant}, 32'h1);
      tick();
      req = 2'b00;
      collect(b, ab, yb);
      chk("rs_byte", {24'd0, b}, 32'h02);
      tick();
      chk("rs_frames_new", {24'd0, frames_sent}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
